pll_loop_filter: RTL and testbench

- Digital PI loop filter for the external PLL, between the AD4008 ADC readout stage and the DAC8411 write stage.
- Consumes one unsigned ADC sample per conversion, computes phase error against a setpoint, and applies proportional and saturating-integral gains.
- Produces a clamped unsigned 16-bit DAC code with a one-cycle valid strobe, plus a lock indicator.

---
 rtl/pll_loop_filter_if.sv | 17 +
 rtl/pll_loop_filter.sv | 164 ++++++++++++++++
 tb/tb_pll_loop_filter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_loop_filter_if.sv
// pll_loop_filter_if: sample/code streaming bundle for the PLL loop filter.
//   adc_data  : unsigned ADC sample, qualified by adc_valid
//   adc_valid : one-cycle strobe from the ADC readout stage
//   dac_code  : registered DAC code, held between updates
//   dac_valid : one-cycle strobe when dac_code updates
// master = ADC readout / DAC write side, slave = loop filter.
interface pll_loop_filter_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  adc_valid;
  logic [DATA_WIDTH-1:0] dac_code;
  logic                  dac_valid;

  modport master (output adc_data, output adc_valid, input dac_code, input dac_valid);
  modport slave  (input adc_data, input adc_valid, output dac_code, output dac_valid);
endinterface

// File: rtl/pll_loop_filter.sv
// pll_loop_filter: digital PI loop filter between ADC readout and DAC write.
//   clk            : system clock
//   sreset         : synchronous active-high reset
//   bus            : adc_data/adc_valid in, dac_code/dac_valid out
//   hold           : freezes integrator and output updates
//   integ_clr      : synchronously zeroes the integrator
//   busy           : sample in flight (state != IDLE)
//   sample_dropped : one-cycle pulse when adc_valid arrives while busy
//   locked         : LOCK_COUNT consecutive samples with |err| <= LOCK_TOL
//
// state | meaning
// IDLE  | waiting for adc_valid, sample captured on acceptance
// ERR   | register err = sample - SETPOINT
// INT   | register p_term, update clamped integrator
// SUM   | register saturated DAC_INIT + p_term + integ/2^KI_SHIFT
// OUT   | load dac_code / strobe dac_valid, update lock tracking
module pll_loop_filter #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SETPOINT   = 16'h8000,
  parameter logic [DATA_WIDTH-1:0] DAC_INIT   = 16'h8000,
  parameter int                    KP_SHIFT   = 2,
  parameter int                    KI_SHIFT   = 6,
  parameter int                    ACC_WIDTH  = 32,
  parameter int                    LOCK_TOL   = 16,
  parameter int                    LOCK_COUNT = 8
) (
  input  logic                     clk,
  input  logic                     sreset,
  pll_loop_filter_if.slave         bus,
  input  logic                     hold,
  input  logic                     integ_clr,
  output logic                     busy,
  output logic                     sample_dropped,
  output logic                     locked
);
  localparam int EW = DATA_WIDTH + 1;
  localparam int SW = ACC_WIDTH + 2;
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int MAG = DATA_WIDTH - 1 + KI_SHIFT;

  // Integrator limits, one guard bit wider than the integrator itself.
  localparam logic signed [ACC_WIDTH:0] INTEG_MAX = {{(ACC_WIDTH + 1 - MAG){1'b0}}, {MAG{1'b1}}};
  localparam logic signed [ACC_WIDTH:0] INTEG_MIN = {{(ACC_WIDTH + 1 - MAG){1'b1}}, {MAG{1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERR  = 3'd1;
  localparam logic [2:0] S_INT  = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]                   state;
  logic [DATA_WIDTH-1:0]        sample_q;
  logic signed [EW-1:0]         err_q;
  logic signed [EW-1:0]         p_q;
  logic signed [ACC_WIDTH-1:0]  integ_q;
  logic [DATA_WIDTH-1:0]        sum_q;
  logic [DATA_WIDTH-1:0]        dac_code_q;
  logic                         dac_valid_q;
  logic                         dropped_q;
  logic                         locked_q;
  logic [CW-1:0]                lock_cnt;

  logic signed [ACC_WIDTH:0]    integ_sum;
  logic signed [ACC_WIDTH:0]    integ_sat;
  logic signed [ACC_WIDTH-1:0]  integ_shr;
  logic signed [SW-1:0]         sum_full;
  logic [DATA_WIDTH-1:0]        sum_sat;
  logic [EW-1:0]                err_abs;
  logic [CW-1:0]                lock_cnt_nxt;

  always_comb begin
    integ_sum = {integ_q[ACC_WIDTH-1], integ_q} + {{(ACC_WIDTH + 1 - EW){err_q[EW-1]}}, err_q};
    if (integ_sum > INTEG_MAX)
      integ_sat = INTEG_MAX;
    else if (integ_sum < INTEG_MIN)
      integ_sat = INTEG_MIN;
    else
      integ_sat = integ_sum;
  end

  always_comb begin
    integ_shr = integ_q >>> KI_SHIFT;
    sum_full  = {{(SW - DATA_WIDTH){1'b0}}, DAC_INIT}
              + {{(SW - EW){p_q[EW-1]}}, p_q}
              + {{(SW - ACC_WIDTH){integ_shr[ACC_WIDTH-1]}}, integ_shr};
    // Negative clamps to zero; anything above the DAC range clamps to full scale.
    if (sum_full[SW-1])
      sum_sat = '0;
    else if (|sum_full[SW-2:DATA_WIDTH])
      sum_sat = '1;
    else
      sum_sat = sum_full[DATA_WIDTH-1:0];
  end

  always_comb begin
    err_abs = err_q[EW-1] ? -err_q : err_q;
    if (err_abs > EW'(LOCK_TOL))
      lock_cnt_nxt = '0;
    else if (lock_cnt == CW'(LOCK_COUNT))
      lock_cnt_nxt = lock_cnt;
    else
      lock_cnt_nxt = lock_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state       <= S_IDLE;
      sample_q    <= '0;
      err_q       <= '0;
      p_q         <= '0;
      integ_q     <= '0;
      sum_q       <= '0;
      dac_code_q  <= DAC_INIT;
      dac_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
      locked_q    <= 1'b0;
      lock_cnt    <= '0;
    end else begin
      dac_valid_q <= 1'b0;
      dropped_q   <= bus.adc_valid && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.adc_valid) begin
            sample_q <= bus.adc_data;
            state    <= S_ERR;
          end
        end
        S_ERR: begin
          err_q <= {1'b0, sample_q} - {1'b0, SETPOINT};
          state <= S_INT;
        end
        S_INT: begin
          p_q <= err_q >>> KP_SHIFT;
          if (!hold)
            integ_q <= integ_sat[ACC_WIDTH-1:0];
          state <= S_SUM;
        end
        S_SUM: begin
          sum_q <= sum_sat;
          state <= S_OUT;
        end
        S_OUT: begin
          if (!hold) begin
            dac_code_q  <= sum_q;
            dac_valid_q <= 1'b1;
          end
          lock_cnt <= lock_cnt_nxt;
          locked_q <= (lock_cnt_nxt == CW'(LOCK_COUNT));
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Placed last so a clear overrides a coincident INT update.
      if (integ_clr)
        integ_q <= '0;
    end
  end

  assign bus.dac_code    = dac_code_q;
  assign bus.dac_valid   = dac_valid_q;
  assign busy            = (state != S_IDLE);
  assign sample_dropped  = dropped_q;
  assign locked          = locked_q;
endmodule

// File: tb/tb_pll_loop_filter.sv
// tb_pll_loop_filter: directed stimulus with a scoreboard queue of expected
// {locked, dac_code} pairs, popped by a monitor on every dac_valid.
module tb_pll_loop_filter;
  logic clk = 1'b0;
  logic sreset;
  logic hold;
  logic integ_clr;
  logic busy;
  logic sample_dropped;
  logic locked;

  pll_loop_filter_if #(.DATA_WIDTH(16)) bus ();

  pll_loop_filter dut (
    .clk            (clk),
    .sreset         (sreset),
    .bus            (bus),
    .hold           (hold),
    .integ_clr      (integ_clr),
    .busy           (busy),
    .sample_dropped (sample_dropped),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  int m_integ;
  int m_cnt;
  bit m_locked;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dac_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_dac_valid: got code 0x%0h, expected no output", bus.dac_code);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({locked, bus.dac_code} !== e) begin
          n_err++;
          $display("FAIL dac_output: got locked=%0b code=0x%0h, expected locked=%0b code=0x%0h",
                   locked, bus.dac_code, e[16], e[15:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_integ = 0;
    m_cnt = 0;
    m_locked = 1'b0;
  endtask

  task automatic do_reset();
    sreset = 1'b1;
    idle(2);
    sreset = 1'b0;
    model_reset();
  endtask

  // Reference arithmetic in plain ints; hand >= 0 overrides the computed code.
  task automatic issue(input logic [15:0] s, input bit h, input int hand);
    int err, p, sum, aerr;
    err = int'(s) - 32768;
    p = err >>> 2;
    if (!h) begin
      m_integ = m_integ + err;
      if (m_integ > 2097151) m_integ = 2097151;
      if (m_integ < -2097152) m_integ = -2097152;
    end
    sum = 32768 + p + (m_integ >>> 6);
    if (sum < 0) sum = 0;
    if (sum > 65535) sum = 65535;
    if (hand >= 0) sum = hand;
    aerr = (err < 0) ? -err : err;
    if (aerr <= 16) m_cnt = (m_cnt == 8) ? 8 : m_cnt + 1;
    else m_cnt = 0;
    m_locked = (m_cnt == 8);
    if (!h) exp_q.push_back({m_locked, 16'(sum)});
    bus.adc_data = s;
    bus.adc_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.adc_valid = 1'b0;
    idle(4);
  endtask

  initial begin
    sreset = 1'b1;
    hold = 1'b0;
    integ_clr = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data = '0;
    model_reset();

    // 1. reset state and aborted sample
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dac_code", bus.dac_code, 32'h8000);
    chk("rst_dac_valid", bus.dac_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_dropped", sample_dropped, 0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    bus.adc_data = 16'h8100;
    bus.adc_valid = 1'b1;
    idle(1);
    bus.adc_valid = 1'b0;
    idle(1);
    sreset = 1'b1;
    idle(2);
    sreset = 1'b0;
    idle(6);
    chk("abort_dac_code", bus.dac_code, 32'h8000);
    chk("abort_busy", busy, 0);

    // 2. single sample, then repeat
    do_reset();
    issue(16'h8100, 1'b0, 16'h8044);
    chk("latency_dac_valid", bus.dac_valid, 1);
    issue(16'h8100, 1'b0, 16'h8048);

    // 3. positive saturation, then recovery
    do_reset();
    issue(16'hFFFF, 1'b0, 16'hA1FE);
    for (int i = 1; i < 70; i++) issue(16'hFFFF, 1'b0, -1);
    chk("pos_sat_code", bus.dac_code, 32'hFFFF);
    issue(16'h0000, 1'b0, 16'hDDFF);
    issue(16'h0000, 1'b0, 16'hDBFF);

    // 4. negative saturation, then zero-error sample
    do_reset();
    for (int i = 0; i < 70; i++) issue(16'h0000, 1'b0, -1);
    chk("neg_sat_code", bus.dac_code, 32'h0000);
    issue(16'h8000, 1'b0, 16'h0000);

    // 5. handshake / drops
    do_reset();
    exp_q.push_back({1'b0, 16'h8044});
    bus.adc_data = 16'h8100;
    bus.adc_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.adc_valid = 1'b0;
    @(negedge clk);
    chk("hs_busy_k", busy, 1);
    @(posedge clk);
    #1;
    bus.adc_data = 16'h0000;
    bus.adc_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.adc_valid = 1'b0;
    @(negedge clk);
    chk("hs_drop_k2", sample_dropped, 1);
    @(posedge clk);
    #1;
    bus.adc_valid = 1'b1;
    @(negedge clk);
    chk("hs_drop_k3", sample_dropped, 0);
    chk("hs_busy_k3", busy, 1);
    @(posedge clk);
    #1;
    bus.adc_valid = 1'b0;
    @(negedge clk);
    chk("hs_drop_k4", sample_dropped, 1);
    chk("hs_busy_k4", busy, 0);
    chk("hs_dac_valid_k4", bus.dac_valid, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hs_drop_k5", sample_dropped, 0);
    idle(6);

    // 6. lock, hold, clear
    do_reset();
    for (int i = 0; i < 8; i++) issue(16'h8008, 1'b0, -1);
    chk("lock_rise", locked, 1);
    issue(16'h8100, 1'b0, 16'h8045);
    chk("lock_fall", locked, 0);
    hold = 1'b1;
    issue(16'h9000, 1'b1, -1);
    hold = 1'b0;
    chk("hold_dac_code", bus.dac_code, 32'h8045);
    issue(16'h8000, 1'b0, 16'h8005);
    integ_clr = 1'b1;
    idle(1);
    integ_clr = 1'b0;
    m_integ = 0;
    issue(16'h8000, 1'b0, 16'h8000);

    idle(10);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
